// File: rtl/bit_memory_array.sv
// bit_memory_array
//   DEPTH lines of WIDTH bits. Each line can be loaded whole, and a single bit
//   can be set or XOR-toggled. Bit and line reads are registered and appear one
//   cycle after the request. A separate scan engine copies one line into a
//   private shift register. It then streams that copy LSB first over a
//   valid/ready handshake.
// Ports
//   clk, rst                 : rising-edge clock, asynchronous active-low reset
//   init, addr, line_in      : load line_in into line[addr]
//   write, xor_en, index, val: set or toggle line[addr][index]
//   read -> out, line_out, out_valid : registered read, one-cycle valid pulse
//   scan_start, scan_addr    : begin streaming a snapshot of line[scan_addr]
//   scan_bit, scan_valid, scan_ready : serial handshake
//   scan_busy, scan_done     : engine active / pulse after the last bit is accepted
module bit_memory_array #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 5,
    parameter int IDXW  = 5,
    parameter int ADDRW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [ADDRW-1:0] addr,
    input  logic [WIDTH-1:0] line_in,
    input  logic [IDXW-1:0]  index,
    input  logic             val,
    input  logic             write,
    input  logic             xor_en,
    input  logic             read,
    output logic             out,
    output logic [WIDTH-1:0] line_out,
    output logic             out_valid,
    input  logic             scan_start,
    input  logic [ADDRW-1:0] scan_addr,
    output logic             scan_bit,
    output logic             scan_valid,
    input  logic             scan_ready,
    output logic             scan_busy,
    output logic             scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             out_q, out_d;
    logic [WIDTH-1:0] line_out_q, line_out_d;
    logic             out_valid_q, out_valid_d;

    scan_state_t      state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             scan_valid_q, scan_valid_d;
    logic             scan_busy_q, scan_busy_d;
    logic             scan_done_q, scan_done_d;

    logic             addr_ok_s, idx_ok_s, scan_addr_ok_s;
    logic [WIDTH-1:0] cur_line_s, scan_line_s, new_line_s;
    logic             cur_bit_s;

    // Decode addresses and index. Out-of-range values match no entry, so they read 0 and write nothing.
    always_comb begin
        addr_ok_s      = 1'b0;
        scan_addr_ok_s = 1'b0;
        idx_ok_s       = 1'b0;
        cur_line_s     = {WIDTH{1'b0}};
        scan_line_s    = {WIDTH{1'b0}};
        cur_bit_s      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDRW'(i)) begin
                addr_ok_s  = 1'b1;
                cur_line_s = mem_q[i];
            end else begin
                addr_ok_s  = addr_ok_s;
            end
            if (scan_addr == ADDRW'(i)) begin
                scan_addr_ok_s = 1'b1;
                scan_line_s    = mem_q[i];
            end else begin
                scan_addr_ok_s = scan_addr_ok_s;
            end
        end
        for (int j = 0; j < WIDTH; j++) begin
            if (index == IDXW'(j)) begin
                idx_ok_s  = 1'b1;
                cur_bit_s = cur_line_s[j];
            end else begin
                idx_ok_s  = idx_ok_s;
            end
        end
    end

    // Build the next value of the addressed line. A bit operation is applied after a same-cycle load.
    always_comb begin
        new_line_s = init ? line_in : cur_line_s;
        for (int j = 0; j < WIDTH; j++) begin
            if (write && (index == IDXW'(j))) begin
                new_line_s[j] = xor_en ? (new_line_s[j] ^ val) : val;
            end else begin
                new_line_s[j] = new_line_s[j];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_ok_s && (addr == ADDRW'(i)) && (init || write)) begin
                mem_d[i] = new_line_s;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Compute the read port. It uses pre-edge contents, so a same-cycle write is not visible.
    always_comb begin
        out_d       = out_q;
        line_out_d  = line_out_q;
        out_valid_d = 1'b0;
        if (read) begin
            out_d       = addr_ok_s && idx_ok_s && cur_bit_s;
            line_out_d  = cur_line_s;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Scan FSM next state. scan_bit is always snap_q[0]; each accepted bit shifts the copy right.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_start && scan_addr_ok_s) begin
                    snap_d  = scan_line_s;
                    cnt_d   = {IDXW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (scan_ready) begin
                    snap_d = snap_q >> 1;
                    if (cnt_q == IDXW'(WIDTH - 1)) begin
                        cnt_d   = {IDXW{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + IDXW'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {IDXW{1'b0}};
            end
        endcase
        scan_valid_d = (state_d == ST_SHIFT);
        scan_busy_d  = (state_d != ST_IDLE);
        scan_done_d  = (state_d == ST_DONE);
    end

    // State register for storage, read port and scan engine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            out_q        <= 1'b0;
            line_out_q   <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= {IDXW{1'b0}};
            snap_q       <= {WIDTH{1'b0}};
            scan_valid_q <= 1'b0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            out_q        <= out_d;
            line_out_q   <= line_out_d;
            out_valid_q  <= out_valid_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            scan_valid_q <= scan_valid_d;
            scan_busy_q  <= scan_busy_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign out        = out_q;
    assign line_out   = line_out_q;
    assign out_valid  = out_valid_q;
    assign scan_bit   = snap_q[0];
    assign scan_valid = scan_valid_q;
    assign scan_busy  = scan_busy_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_bit_memory_array.sv
module tb_bit_memory_array;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [24:0] line_in = 25'd0;
    logic [4:0]  index = 5'd0;
    logic        val = 1'b0;
    logic        write = 1'b0;
    logic        xor_en = 1'b0;
    logic        read = 1'b0;
    logic        out;
    logic [24:0] line_out;
    logic        out_valid;
    logic        scan_start = 1'b0;
    logic [2:0]  scan_addr = 3'd0;
    logic        scan_bit;
    logic        scan_valid;
    logic        scan_ready = 1'b0;
    logic        scan_busy;
    logic        scan_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [24:0] exp_line;

    bit_memory_array dut (
        .clk(clk), .rst(rst), .init(init), .addr(addr), .line_in(line_in),
        .index(index), .val(val), .write(write), .xor_en(xor_en), .read(read),
        .out(out), .line_out(line_out), .out_valid(out_valid),
        .scan_start(scan_start), .scan_addr(scan_addr), .scan_bit(scan_bit),
        .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_busy(scan_busy),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [4:0] i);
        addr = a; index = i; read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic do_init(input logic [2:0] a, input logic [24:0] d);
        addr = a; line_in = d; init = 1'b1;
        step();
        init = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [4:0] i, input logic v, input logic x);
        addr = a; index = i; val = v; xor_en = x; write = 1'b1;
        step();
        write = 1'b0; xor_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic o, input logic [24:0] l);
        check_eq({tag, ".out"}, 32'(out), 32'(o));
        check_eq({tag, ".line"}, 32'(line_out), 32'(l));
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        step();
        check_eq("rst.out", 32'(out), 32'd0);
        check_eq("rst.valid", 32'(out_valid), 32'd0);
        check_eq("rst.busy", 32'(scan_busy), 32'd0);
        check_eq("rst.svalid", 32'(scan_valid), 32'd0);
        rst = 1'b1;
        step();

        // Every line reads zero after reset, with one valid pulse per read
        for (int a = 0; a < 5; a++) begin
            do_read(3'(a), 5'd0);
            check_read("rdzero", 1'b0, 25'd0);
            step();
            check_eq("rdzero.pulse", 32'(out_valid), 32'd0);
        end

        // Load a line, then clear bit 0
        do_init(3'd2, 25'h1ABCDEF);
        do_read(3'd2, 5'd0);
        check_read("init", 1'b1, 25'h1ABCDEF);
        do_write(3'd2, 5'd0, 1'b0, 1'b0);
        do_read(3'd2, 5'd0);
        check_read("wr0", 1'b0, 25'h1ABCDEE);

        // XOR toggle, xor_en without write, and out-of-range index
        do_write(3'd1, 5'd7, 1'b1, 1'b1);
        do_read(3'd1, 5'd7);
        check_read("xor1", 1'b1, 25'h0000080);
        addr = 3'd1; index = 5'd7; val = 1'b1; xor_en = 1'b1;
        step();
        xor_en = 1'b0;
        do_read(3'd1, 5'd7);
        check_read("xornowr", 1'b1, 25'h0000080);
        do_write(3'd1, 5'd7, 1'b1, 1'b1);
        do_read(3'd1, 5'd7);
        check_read("xor2", 1'b0, 25'h0000000);
        do_write(3'd1, 5'd30, 1'b1, 1'b0);
        do_read(3'd1, 5'd30);
        check_read("idx30", 1'b0, 25'h0000000);

        // Same-cycle init + write on line 3
        do_init(3'd3, 25'h0000F00);
        addr = 3'd3; line_in = 25'd0; init = 1'b1; index = 5'd4; val = 1'b1; write = 1'b1;
        step();
        init = 1'b0; write = 1'b0;
        do_read(3'd3, 5'd4);
        check_read("initwr", 1'b1, 25'h0000010);

        // Read and write of the same bit on the same edge returns the old value
        addr = 3'd3; index = 5'd4; val = 1'b0; write = 1'b1; read = 1'b1;
        step();
        write = 1'b0; read = 1'b0;
        check_read("rdwr.old", 1'b1, 25'h0000010);
        do_read(3'd3, 5'd4);
        check_read("rdwr.new", 1'b0, 25'h0000000);

        // Out-of-range address: load ignored, read returns zeros
        do_init(3'd6, 25'h1FFFFFF);
        do_read(3'd6, 5'd0);
        check_read("addr6", 1'b0, 25'h0000000);

        // Scan line 2 with ready high; busy restart and mid-scan load must not disturb it
        do_init(3'd2, 25'h1ABCDEF);
        exp_line = 25'h1ABCDEF;
        scan_addr = 3'd2; scan_start = 1'b1; scan_ready = 1'b1;
        step();
        scan_start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            check_eq("scan1.valid", 32'(scan_valid), 32'd1);
            check_eq("scan1.bit", 32'(scan_bit), 32'(exp_line[k]));
            if (k == 3) begin
                scan_start = 1'b1; scan_addr = 3'd1;
            end else if (k == 5) begin
                addr = 3'd2; line_in = 25'd0; init = 1'b1;
            end else begin
                scan_start = 1'b0;
            end
            step();
            scan_start = 1'b0; init = 1'b0;
        end
        check_eq("scan1.done", 32'(scan_done), 32'd1);
        check_eq("scan1.doneval", 32'(scan_valid), 32'd0);
        check_eq("scan1.donebusy", 32'(scan_busy), 32'd1);
        step();
        check_eq("scan1.idledone", 32'(scan_done), 32'd0);
        check_eq("scan1.idlebusy", 32'(scan_busy), 32'd0);
        do_read(3'd2, 5'd0);
        check_read("scan1.midload", 1'b0, 25'h0000000);

        // Scan line 4 with ready toggling; each bit held while not accepted
        do_init(3'd4, 25'h0F0F0F3);
        exp_line = 25'h0F0F0F3;
        scan_addr = 3'd4; scan_start = 1'b1; scan_ready = 1'b0;
        step();
        scan_start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            check_eq("scan2.bit", 32'(scan_bit), 32'(exp_line[k]));
            scan_ready = 1'b0;
            step();
            check_eq("scan2.hold", 32'(scan_bit), 32'(exp_line[k]));
            check_eq("scan2.valid", 32'(scan_valid), 32'd1);
            scan_ready = 1'b1;
            step();
        end
        check_eq("scan2.done", 32'(scan_done), 32'd1);
        scan_ready = 1'b0;
        step();
        check_eq("scan2.idle", 32'(scan_busy), 32'd0);

        // Reset in the middle of a scan at bit 10
        scan_addr = 3'd4; scan_start = 1'b1; scan_ready = 1'b1;
        step();
        scan_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
        end
        check_eq("scan3.bit10", 32'(scan_bit), 32'(exp_line[10]));
        rst = 1'b0;
        #1;
        check_eq("arst.valid", 32'(scan_valid), 32'd0);
        check_eq("arst.busy", 32'(scan_busy), 32'd0);
        check_eq("arst.done", 32'(scan_done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("arst.nodone", 32'(scan_done), 32'd0);
        end
        rst = 1'b1;
        scan_ready = 1'b0;
        step();
        check_eq("arst.nobusy", 32'(scan_busy), 32'd0);
        do_read(3'd4, 5'd0);
        check_read("arst.mem4", 1'b0, 25'h0000000);
        do_read(3'd1, 5'd7);
        check_read("arst.mem1", 1'b0, 25'h0000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
